fetch_stage: RTL and testbench

// Instruction-fetch stage of the pipelined RV32I core: owns the PC, drives a

---
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem
// and fills the IF/ID register with a one-entry skid for stalls.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   o_imem_ren            read request this cycle
//   o_imem_raddr          read address (word aligned, = pc_q)
//   i_imem_rdata          data for the address requested last cycle
//   i_stall               decode cannot accept: hold PC and IF/ID
//   i_redirect            taken branch/jump: squash and refetch
//   i_redirect_pc         target PC, valid with i_redirect
//   o_id_valid            IF/ID holds a real instruction
//   o_id_inst             IF/ID instruction (NOP_INST when invalid)
//   o_id_pc, o_id_pc4     PC of o_id_inst and PC + 4 (link value)
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_ren,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_id_valid,
    output logic [31:0] o_id_inst,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pc4
);

    localparam logic [31:0] WORD = 32'd4;

    // RUN: skid empty. HELD: skid holds a returned word awaiting decode.
    typedef enum logic {
        RUN,
        HELD
    } mode_e;

    mode_e       mode_q, mode_d;
    logic [31:0] pc_q, pc_d;
    logic        infl_v_q, infl_v_d;
    logic [31:0] infl_pc_q, infl_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        ren;
    logic        do_redirect;
    logic        do_stall;
    logic        do_run;

    // Mutually exclusive cycle actions: redirect beats stall beats normal.
    assign do_redirect = i_redirect;
    assign do_stall    = !i_redirect && i_stall;
    assign do_run      = !i_redirect && !i_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q      <= RUN;
            pc_q        <= RESET_ADDR;
            infl_v_q    <= 1'b0;
            infl_pc_q   <= 32'h0;
            hold_inst_q <= NOP_INST;
            hold_pc_q   <= 32'h0;
            id_valid_q  <= 1'b0;
            id_inst_q   <= NOP_INST;
            id_pc_q     <= 32'h0;
            id_pc4_q    <= WORD;
        end else begin
            mode_q      <= mode_d;
            pc_q        <= pc_d;
            infl_v_q    <= infl_v_d;
            infl_pc_q   <= infl_pc_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            id_valid_q  <= id_valid_d;
            id_inst_q   <= id_inst_d;
            id_pc_q     <= id_pc_d;
            id_pc4_q    <= id_pc4_d;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        pc_d        = pc_q;
        infl_v_d    = infl_v_q;
        infl_pc_d   = infl_pc_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        id_valid_d  = id_valid_q;
        id_inst_d   = id_inst_q;
        id_pc_d     = id_pc_q;
        id_pc4_d    = id_pc4_q;
        ren         = 1'b0;

        unique case (1'b1)
            do_redirect: begin
                // Drop everything in flight or held; target is
                // fetched on the following cycle.
                pc_d       = {i_redirect_pc[31:2], 2'b00};
                infl_v_d   = 1'b0;
                mode_d     = RUN;
                id_valid_d = 1'b0;
                id_inst_d  = NOP_INST;
            end
            do_stall: begin
                // A word returning now would be lost; park it in
                // the skid so release costs no bubble.
                infl_v_d = 1'b0;
                if (mode_q == RUN && infl_v_q) begin
                    hold_inst_d = i_imem_rdata;
                    hold_pc_d   = infl_pc_q;
                    mode_d      = HELD;
                end
            end
            do_run: begin
                ren       = 1'b1;
                infl_pc_d = pc_q;
                infl_v_d  = 1'b1;
                pc_d      = pc_q + WORD;
                if (mode_q == HELD) begin
                    id_valid_d = 1'b1;
                    id_inst_d  = hold_inst_q;
                    id_pc_d    = hold_pc_q;
                    id_pc4_d   = hold_pc_q + WORD;
                    mode_d     = RUN;
                end else if (infl_v_q) begin
                    id_valid_d = 1'b1;
                    id_inst_d  = i_imem_rdata;
                    id_pc_d    = infl_pc_q;
                    id_pc4_d   = infl_pc_q + WORD;
                end else begin
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end
            end
            default: begin
                ren = 1'b0;
            end
        endcase
    end

    // Gate the request with reset so nothing is issued while held in reset.
    assign o_imem_ren   = ren && i_rst_n;
    assign o_imem_raddr = pc_q;
    assign o_id_valid   = id_valid_q;
    assign o_id_inst    = id_inst_q;
    assign o_id_pc      = id_pc_q;
    assign o_id_pc4     = id_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based fetch model plus directed literals.
// Imem returns word (addr >> 2) one cycle after a request, garbage otherwise.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        ren;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_ren    (ren),
        .o_imem_raddr  (raddr),
        .i_imem_rdata  (rdata),
        .i_stall       (stall),
        .i_redirect    (redir),
        .i_redirect_pc (rpc),
        .o_id_valid    (id_valid),
        .o_id_inst     (id_inst),
        .o_id_pc       (id_pc),
        .o_id_pc4      (id_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rdata = GARBAGE;
    always @(posedge clk) begin
        rdata <= ren ? (raddr >> 2) : GARBAGE;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: next fetch address plus a FIFO of fetched, undelivered
    // addresses. Stalls freeze it, redirects flush it.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_q[$];
    logic        m_v = 1'b0;
    logic [31:0] m_idpc = 32'h0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pc = 32'h0;
                m_q.delete();
                m_v = 1'b0;
                m_idpc = 32'h0;
            end else if (redir) begin
                m_pc = {rpc[31:2], 2'b00};
                m_q.delete();
                m_v = 1'b0;
            end else if (!stall) begin
                if (m_q.size() > 0) begin
                    m_idpc = m_q.pop_front();
                    m_v = 1'b1;
                end else begin
                    m_v = 1'b0;
                end
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_ren", {31'b0, ren},
                {31'b0, rst_n && !stall && !redir});
            chk("m_raddr", raddr, m_pc);
            chk("m_valid", {31'b0, id_valid}, {31'b0, m_v});
            chk("m_inst", id_inst, m_v ? (m_idpc >> 2) : NOP);
            if (m_v) begin
                chk("m_pc", id_pc, m_idpc);
                chk("m_pc4", id_pc4, m_idpc + 32'd4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] p);
        stall = s;
        redir = r;
        rpc   = p;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ren"}, {31'b0, ren}, 32'd0);
        chk({tag, "_raddr"}, raddr, 32'h0);
        chk({tag, "_valid"}, {31'b0, id_valid}, 32'd0);
        chk({tag, "_inst"}, id_inst, NOP);
        chk({tag, "_pc"}, id_pc, 32'h0);
        chk({tag, "_pc4"}, id_pc4, 32'h4);
    endtask

    logic [1:0] pat [12] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00,
                             2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redir = 1'b0;
        rpc   = 32'h0;
        repeat (2) @(negedge clk);
        #2;
        chk_reset_vals("rst");

        // Reset release and steady stream.
        rst_n = 1'b1;
        step(0, 0, 0);
        chk("t1_raddr", raddr, 32'h4);
        chk("t1_v0", {31'b0, id_valid}, 32'd0);
        step(0, 0, 0);
        chk("t1_v1", {31'b0, id_valid}, 32'd1);
        chk("t1_inst", id_inst, 32'h0);
        chk("t1_pc", id_pc, 32'h0);
        chk("t1_pc4", id_pc4, 32'h4);
        step(0, 0, 0);
        chk("t1_pc_b", id_pc, 32'h4);

        // Stall three cycles with pc 8 in flight.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk("t2_frozen", id_pc, 32'h4);
            chk("t2_ren", {31'b0, ren}, 32'd0);
        end
        step(0, 0, 0);
        chk("t2_pc8", id_pc, 32'h8);
        chk("t2_inst8", id_inst, 32'h2);
        step(0, 0, 0);
        chk("t2_pc12", id_pc, 32'hC);
        chk("t2_inst12", id_inst, 32'h3);

        // Redirect to 0x100 while 0x20 in flight.
        repeat (4) step(0, 0, 0);
        chk("t3_pre", id_pc, 32'h1C);
        step(0, 1, 32'h100);
        chk("t3_b1", {31'b0, id_valid}, 32'd0);
        chk("t3_nop", id_inst, NOP);
        step(0, 0, 0);
        chk("t3_b2", {31'b0, id_valid}, 32'd0);
        chk("t3_raddr", raddr, 32'h104);
        step(0, 0, 0);
        chk("t3_pc", id_pc, 32'h100);
        chk("t3_inst", id_inst, 32'h40);

        // Redirect plus stall while HELD.
        step(1, 0, 0);
        chk("t4_held", id_pc, 32'h100);
        step(1, 1, 32'h103);
        chk("t4_v", {31'b0, id_valid}, 32'd0);
        chk("t4_raddr", raddr, 32'h100);
        step(0, 0, 0);
        chk("t4_b", {31'b0, id_valid}, 32'd0);
        step(0, 0, 0);
        chk("t4_pc", id_pc, 32'h100);
        chk("t4_inst", id_inst, 32'h40);

        // Address wrap.
        step(0, 1, 32'hFFFF_FFF8);
        step(0, 0, 0);
        chk("t5_raddr", raddr, 32'hFFFF_FFFC);
        step(0, 0, 0);
        chk("t5_pcf8", id_pc, 32'hFFFF_FFF8);
        chk("t5_raddr0", raddr, 32'h0);
        step(0, 0, 0);
        chk("t5_pcfc", id_pc, 32'hFFFF_FFFC);
        chk("t5_pc4wrap", id_pc4, 32'h0);
        step(0, 0, 0);
        chk("t5_pc0", id_pc, 32'h0);
        chk("t5_pc4", id_pc4, 32'h4);

        // Mixed stall/redirect pattern, model-checked.
        for (int i = 0; i < 12; i++) begin
            step(pat[i][0], pat[i][1], 32'h200 + 32'(i) * 32'h14);
        end
        repeat (3) step(0, 0, 0);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step(0, 0, 0);
        chk("t6_raddr", raddr, 32'h4);
        chk("t6_v0", {31'b0, id_valid}, 32'd0);
        step(0, 0, 0);
        chk("t6_pc", id_pc, 32'h0);
        chk("t6_v1", {31'b0, id_valid}, 32'd1);
        repeat (2) step(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
